// File: rtl/instr_encoder.sv
// Instruction encoder: turns a one-hot class plus operand fields into a 32-bit
// RV32I word and queues it, with its byte address, in a 4-entry FIFO.
module instr_encoder (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [8:0]  type_oh,
    input  logic [2:0]  f3,
    input  logic [6:0]  f7,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic [31:0] immediate,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic [31:0] addr,
    output logic [2:0]  count,
    output logic        err
);

    localparam int unsigned Depth = 4;

    localparam logic [8:0] ClsR      = 9'h100;
    localparam logic [8:0] ClsIAlu   = 9'h080;
    localparam logic [8:0] ClsLoad   = 9'h040;
    localparam logic [8:0] ClsStore  = 9'h020;
    localparam logic [8:0] ClsBranch = 9'h010;
    localparam logic [8:0] ClsJal    = 9'h008;
    localparam logic [8:0] ClsLui    = 9'h004;
    localparam logic [8:0] ClsAuipc  = 9'h002;
    localparam logic [8:0] ClsJalr   = 9'h001;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpIAlu   = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    logic [31:0] r_mem [Depth];
    logic [1:0]  r_wptr;
    logic [1:0]  r_rptr;
    logic [2:0]  r_count;
    logic [31:0] r_addr;
    logic        r_err;

    logic        w_onehot0;
    logic        w_shift;
    logic        w_f7_std;
    logic        w_illegal;
    logic [31:0] w_enc;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;

    assign w_onehot0 = ((type_oh & (type_oh - 9'd1)) == 9'd0);
    assign w_shift   = (f3 == 3'd1) || (f3 == 3'd5);
    assign w_f7_std  = (f7 == 7'h00) || (f7 == 7'h20);

    always_comb begin
        w_illegal = !w_onehot0;
        if (w_onehot0) begin
            case (type_oh)
                ClsR:      w_illegal = !((f7 == 7'h00) ||
                                         ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
                ClsIAlu:   w_illegal = w_shift && !w_f7_std;
                ClsLoad:   w_illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
                ClsStore:  w_illegal = (f3 > 3'd2);
                ClsBranch: w_illegal = (f3 == 3'd2) || (f3 == 3'd3);
                ClsJalr:   w_illegal = (f3 != 3'd0);
                default:   w_illegal = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_enc = 32'h0000_0000;
        case (type_oh)
            ClsR:      w_enc = {f7, rs2, rs1, f3, rd, OpR};
            ClsIAlu:   w_enc = w_shift ? {f7, immediate[4:0], rs1, f3, rd, OpIAlu}
                                       : {immediate[11:0], rs1, f3, rd, OpIAlu};
            ClsLoad:   w_enc = {immediate[11:0], rs1, f3, rd, OpLoad};
            ClsStore:  w_enc = {immediate[11:5], rs2, rs1, f3, immediate[4:0], OpStore};
            ClsBranch: w_enc = {immediate[12], immediate[10:5], rs2, rs1, f3,
                                immediate[4:1], immediate[11], OpBranch};
            ClsJal:    w_enc = {immediate[20], immediate[10:1], immediate[11],
                                immediate[19:12], rd, OpJal};
            ClsLui:    w_enc = {immediate[31:12], rd, OpLui};
            ClsAuipc:  w_enc = {immediate[31:12], rd, OpAuipc};
            ClsJalr:   w_enc = {immediate[11:0], rs1, 3'b000, rd, OpJalr};
            default:   w_enc = 32'h0000_0000;
        endcase
    end

    assign in_ready  = (r_count != 3'(Depth));
    assign out_valid = (r_count != 3'd0);
    assign w_accept  = in_valid && in_ready;
    // Illegal requests complete the handshake but never reach the FIFO.
    assign w_push    = w_accept && !w_illegal;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < Depth; i++) begin
                r_mem[i] <= 32'h0000_0000;
            end
            r_wptr  <= 2'd0;
            r_rptr  <= 2'd0;
            r_count <= 3'd0;
            r_addr  <= 32'h0000_0000;
            r_err   <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_enc;
                r_wptr        <= r_wptr + 2'd1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 2'd1;
                r_addr <= r_addr + 32'd4;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
            if (w_accept && w_illegal) begin
                r_err <= 1'b1;
            end
        end
    end

    assign instr = out_valid ? r_mem[r_rptr] : 32'h0000_0000;
    assign addr  = r_addr;
    assign count = r_count;
    assign err   = r_err;

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL: one clock; reset is asynchronous and active-low; ports named clock and reset_n.
REQ-002 SHALL: clock  input  1  rising-edge clock for all state.
REQ-003 SHALL: reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL: in_valid  input  1  field bundle presented.
REQ-005 SHALL: in_ready  output  1  encoder can accept; equals !full.
REQ-006 SHALL: type  input  9  one-hot class, same map as decoder: [8]R [7]I-ALU [6]LOAD [5]STORE [4]BRANCH [3]JAL [2]LUI [1]AUIPC [0]JALR; 0 = NOP.
REQ-007 SHALL: f3  input  3; f7  input  7; rs1, rs2, rd  input  5 each; immediate  input  32.
REQ-008 SHALL: out_valid  output  1  FIFO head holds an encoded word.
REQ-009 SHALL: out_ready  input  1  consumer (instruction-memory writer) takes head.
REQ-010 SHALL: instr  output  32  encoded word at FIFO head.
REQ-011 SHALL: addr  output  32  byte address for head word.
REQ-012 SHALL: count  output  3  FIFO occupancy 0..4.
REQ-013 SHALL: err  output  1  sticky illegal-request flag.

Function
REQ-014 SHALL: accept on rising edge with in_valid & in_ready; legal requests are encoded combinationally and written into a 4-entry FIFO at that same edge.
REQ-015 SHALL: out_valid = (count != 0); first word visible the cycle after acceptance (latency 1).
REQ-016 SHALL: pop on edge with out_valid & out_ready; addr then increments by 4, wrapping 0xFFFFFFFC -> 0x00000000.
REQ-017 SHALL: push and pop in the same edge leave count unchanged, order preserved.
REQ-018 SHALL: full (count==4) drives in_ready low; in_valid ignored while full.
REQ-019 SHALL: R: {f7,rs2,rs1,f3,rd,0110011}.
REQ-020 SHALL: I-ALU (0010011) and LOAD (0000011): {imm[11:0],rs1,f3,rd,op}; I-ALU with f3=1 or 5 uses {f7,imm[4:0],rs1,f3,rd,op}.
REQ-021 SHALL: STORE: {imm[11:5],rs2,rs1,f3,imm[4:0],0100011}.
REQ-022 SHALL: BRANCH: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],1100011}.
REQ-023 SHALL: JAL: {imm[20],imm[10:1],imm[11],imm[19:12],rd,1101111}.
REQ-024 SHALL: LUI/AUIPC: {imm[31:12],rd,0110111/0010111}; JALR: {imm[11:0],rs1,000,rd,1100111}.
REQ-025 SHALL: type==0 enqueues 0x00000000 (NOP).
REQ-026 SHALL: illegal = type not one-hot-or-zero, LOAD f3 in {3,6,7}, STORE f3>2, BRANCH f3 in {2,3}, JALR f3!=0, I-ALU shift with f7 not 0x00/0x20, R with f7 not 0x00/0x20 (0x20 only for f3 0/5).
REQ-027 SHALL: illegal requests are accepted (handshake completes) but not enqueued, and set err until reset.
REQ-028 SHALL: unused immediate bits ignored; no range checking on immediate.

Reset
REQ-029 SHALL: reset_n low asynchronously clears FIFO, count=0, out_valid=0, in_ready=1, addr=0, err=0, instr=0.
REQ-030 SHALL: reset mid-operation discards all queued words; first word after release goes to addr 0.

Verification
REQ-031 SHALL: R, f7=0, rs2=2, rs1=1, f3=0, rd=3 -> instr 0x002081B3, addr 0, out_valid one cycle later.
REQ-032 SHALL: sequence ADDI x1,x0,5; SW x2,8(x1); BEQ x1,x2,+8; JAL x1,+16; LUI x5,0x12345000 with out_ready=1 -> 0x00500093 @0, 0x0020A423 @4, 0x00208463 @8, 0x010000EF @12, 0x123452B7 @16.
REQ-033 SHALL: out_ready=0, five back-to-back requests -> four accepted, count=4, in_ready=0; then out_ready=1 -> words drain in order, fifth accepted after first pop.
REQ-034 SHALL: type=9'h003 or LOAD with f3=7 -> in_ready stays high, count unchanged, err=1 next cycle and held.
REQ-035 SHALL: reset_n pulsed low with count=3 -> count=0, out_valid=0, err=0 immediately; next word at addr 0.
REQ-036 SHALL: simultaneous push/pop at count=2 -> count stays 2, output order preserved.
